// File: rtl/sap2_prog_loader_pkg.sv
// Shared types and defaults for the SAP-2 program loader.
package sap2_prog_loader_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDR   = 3'd1,
    S_DATA   = 3'd2,
    S_VERIFY = 3'd3,
    S_DONE   = 3'd4
  } state_e;

endpackage

// File: rtl/sap2_loader_addr_ctr.sv
// Loader address/count registers: load on start, step after each written byte.
module sap2_loader_addr_ctr
  import sap2_prog_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W:0]   cnt,
  output logic              cnt_zero,
  output logic              cnt_one
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;

  always_comb begin
    addr_d = addr_q;
    cnt_d  = cnt_q;
    if (load) begin
      addr_d = base_addr;
      cnt_d  = len;
    end else if (step) begin
      // Address wraps naturally at 2^ADDR_W.
      addr_d = addr_q + 1'b1;
      cnt_d  = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      addr_q <= '0;
      cnt_q  <= '0;
    end else begin
      addr_q <= addr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign addr     = addr_q;
  assign cnt      = cnt_q;
  assign cnt_zero = (cnt_q == '0);
  assign cnt_one  = (cnt_q == {{ADDR_W{1'b0}}, 1'b1});

endmodule

// File: rtl/sap2_prog_loader.sv
// SAP-2 program-mode loader: streams bytes into RAM via the MAR program input.
// Optional read-back check enabled by `SAP2_LOADER_VERIFY_EN.
module sap2_prog_loader
  import sap2_prog_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              prog,
  output logic              lm,
  output logic [ADDR_W-1:0] mar_in,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_e            state_q, state_d;
  logic              ctr_load, ctr_step;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   cnt;
  logic              cnt_zero, cnt_one;
  logic              err_set, err_clr;

  sap2_loader_addr_ctr #(.ADDR_W(ADDR_W)) u_ctr (
    .clk      (clk),
    .clr      (clr),
    .load     (ctr_load),
    .step     (ctr_step),
    .base_addr(base_addr),
    .len      (len),
    .addr     (addr),
    .cnt      (cnt),
    .cnt_zero (cnt_zero),
    .cnt_one  (cnt_one)
  );

`ifdef SAP2_LOADER_VERIFY_EN
  logic [DATA_W-1:0] data_q, data_d;
  logic              err_q, err_d;
`else
  logic unused_sig;
  assign unused_sig = ^{ram_dout, cnt_zero, cnt};
`endif

  always_comb begin
    state_d  = state_q;
    ctr_load = 1'b0;
    ctr_step = 1'b0;
    err_set  = 1'b0;
    err_clr  = 1'b0;
    in_ready = 1'b0;
    prog     = 1'b0;
    lm       = 1'b0;
    mar_in   = '0;
    ram_we   = 1'b0;
    ram_din  = '0;
    done     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          ctr_load = 1'b1;
          err_clr  = 1'b1;
          state_d  = (len == '0) ? S_DONE : S_ADDR;
        end
      end
      S_ADDR: begin
        prog    = 1'b1;
        lm      = 1'b1;
        mar_in  = addr;
        state_d = S_DATA;
      end
      S_DATA: begin
        prog     = 1'b1;
        in_ready = 1'b1;
        if (in_valid) begin
          ram_we   = 1'b1;
          ram_din  = in_data;
          ctr_step = 1'b1;
`ifdef SAP2_LOADER_VERIFY_EN
          state_d  = S_VERIFY;
`else
          // cnt_one is the pre-decrement count: this was the last byte.
          state_d  = cnt_one ? S_DONE : S_ADDR;
`endif
        end
      end
`ifdef SAP2_LOADER_VERIFY_EN
      S_VERIFY: begin
        prog    = 1'b1;
        err_set = (ram_dout != data_q);
        state_d = cnt_zero ? S_DONE : S_ADDR;
      end
`endif
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (abort && state_q != S_IDLE) state_d = S_IDLE;

    // clr suppresses every strobe in the cycle it is asserted.
    if (clr) begin
      ctr_load = 1'b0;
      ctr_step = 1'b0;
      in_ready = 1'b0;
      prog     = 1'b0;
      lm       = 1'b0;
      mar_in   = '0;
      ram_we   = 1'b0;
      ram_din  = '0;
      done     = 1'b0;
    end
  end

  assign busy     = !clr && (state_q != S_IDLE);
  assign cpu_hold = busy;

`ifdef SAP2_LOADER_VERIFY_EN
  always_comb begin
    data_d = ctr_step ? in_data : data_q;
    err_d  = err_q;
    if (err_clr)      err_d = 1'b0;
    else if (err_set) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      err_q  <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (clr) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

endmodule
